ballot_tally_core: RTL and testbench

//  Three-candidate electronic ballot counter. Counts one vote per press of a

---
 rtl/ballot_tally_core_if.sv | 33 +++
 rtl/ballot_tally_core.sv | 81 ++++++++
 tb/tb_ballot_tally_core.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ballot_tally_core_if.sv
// Button/close inputs and published vote totals
// for the three-candidate ballot tally core.
interface ballot_tally_core_if #(
    parameter int COUNT_W = 32
);
    logic               i_candidate_1;
    logic               i_candidate_2;
    logic               i_candidate_3;
    logic               i_voting_over;
    logic [COUNT_W-1:0] o_count1;
    logic [COUNT_W-1:0] o_count2;
    logic [COUNT_W-1:0] o_count3;

    modport master (
        output i_candidate_1,
        output i_candidate_2,
        output i_candidate_3,
        output i_voting_over,
        input  o_count1,
        input  o_count2,
        input  o_count3
    );

    modport slave (
        input  i_candidate_1,
        input  i_candidate_2,
        input  i_candidate_3,
        input  i_voting_over,
        output o_count1,
        output o_count2,
        output o_count3
    );
endinterface

// File: rtl/ballot_tally_core.sv
// Three-candidate ballot counter: one vote per press
// while open, totals frozen and published once closed.
module ballot_tally_core #(
    parameter int COUNT_W = 32
) (
    input logic           clk,
    input logic           rst,
    ballot_tally_core_if.slave bus
);
    typedef enum logic [1:0] {
        OPEN,
        HOLD,
        CLOSED
    } state_t;

    localparam logic [COUNT_W-1:0] MAX = '1;

    state_t state_q;
    state_t state_d;

    logic [2:0] btn;
    logic [2:0] btn_q;
    logic [2:0] inc;

    logic [2:0][COUNT_W-1:0] cnt_q;
    logic [2:0][COUNT_W-1:0] out_q;

    assign btn = {bus.i_candidate_3,
                  bus.i_candidate_2,
                  bus.i_candidate_1};

    always_comb begin
        state_d = state_q;
        inc     = '0;
        unique case (state_q)
            OPEN: begin
                if (bus.i_voting_over) begin
                    state_d = CLOSED;
                end else if (|btn) begin
                    // Any press (valid or not) waits for full release
                    state_d = HOLD;
                    if ($onehot(btn) && |(btn & ~btn_q))
                        inc = btn;
                end
            end
            HOLD: begin
                if (bus.i_voting_over)
                    state_d = CLOSED;
                else if (btn == 3'b000)
                    state_d = OPEN;
            end
            CLOSED: state_d = CLOSED;
            default: state_d = OPEN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= OPEN;
            btn_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            btn_q   <= btn;
            for (int i = 0; i < 3; i++) begin
                if (inc[i] && cnt_q[i] != MAX)
                    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
            // Totals stay hidden until polling has closed
            if (state_q == CLOSED)
                out_q <= cnt_q;
            else
                out_q <= '0;
        end
    end

    assign bus.o_count1 = out_q[0];
    assign bus.o_count2 = out_q[1];
    assign bus.o_count3 = out_q[2];
endmodule

// File: tb/tb_ballot_tally_core.sv
// Scoreboard bench for ballot_tally_core, run on
// a 32-bit and a 2-bit (saturating) instance.
module tb_ballot_tally_core;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [2:0] btn = 3'b000;
    logic vo = 1'b0;

    always #5 clk = ~clk;

    ballot_tally_core_if #(.COUNT_W(32)) bw ();
    ballot_tally_core_if #(.COUNT_W(2))  bn ();

    assign bw.i_candidate_1 = btn[0];
    assign bw.i_candidate_2 = btn[1];
    assign bw.i_candidate_3 = btn[2];
    assign bw.i_voting_over = vo;
    assign bn.i_candidate_1 = btn[0];
    assign bn.i_candidate_2 = btn[1];
    assign bn.i_candidate_3 = btn[2];
    assign bn.i_voting_over = vo;

    ballot_tally_core #(.COUNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bw.slave)
    );

    ballot_tally_core #(.COUNT_W(2)) dut_n (
        .clk (clk),
        .rst (rst),
        .bus (bn.slave)
    );

    typedef struct {
        string tag;
        int    c [3];
    } exp_t;

    exp_t sb [$];
    int   m [3];
    bit   closed;
    int   errors = 0;
    int   checks = 0;

    task automatic check(string tag,
                         logic [63:0] act,
                         logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic zeros(string tag);
        check({tag, ".w1"}, 64'(bw.o_count1), 0);
        check({tag, ".w2"}, 64'(bw.o_count2), 0);
        check({tag, ".w3"}, 64'(bw.o_count3), 0);
        check({tag, ".n"},
              64'({bn.o_count1, bn.o_count2, bn.o_count3}),
              0);
    endtask

    task automatic push(string tag);
        exp_t e;
        e.tag = tag;
        e.c   = m;
        sb.push_back(e);
    endtask

    function automatic int sat2(int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".w1"}, 64'(bw.o_count1), 64'(e.c[0]));
            check({e.tag, ".w2"}, 64'(bw.o_count2), 64'(e.c[1]));
            check({e.tag, ".w3"}, 64'(bw.o_count3), 64'(e.c[2]));
            check({e.tag, ".n1"}, 64'(bn.o_count1), 64'(sat2(e.c[0])));
            check({e.tag, ".n2"}, 64'(bn.o_count2), 64'(sat2(e.c[1])));
            check({e.tag, ".n3"}, 64'(bn.o_count3), 64'(sat2(e.c[2])));
        end
    endtask

    task automatic do_reset();
        btn = 3'b000;
        vo  = 1'b0;
        rst = 1'b0;
        tick();
        rst    = 1'b1;
        m      = '{0, 0, 0};
        closed = 1'b0;
        tick();
    endtask

    task automatic press(int n, string tag);
        btn = 3'(1 << n);
        if (!closed)
            m[n] = m[n] + 1;
        tick();
        btn = 3'b000;
        tick();
        tick();
        if (!closed)
            zeros(tag);
    endtask

    // Outputs stay 0 on the closing edge, load on the next
    task automatic close_poll(string tag);
        vo     = 1'b1;
        closed = 1'b1;
        push(tag);
        tick();
        zeros({tag, ".pre"});
        tick();
        drain();
    endtask

    initial begin
        m      = '{0, 0, 0};
        closed = 1'b0;

        // Reset held with buttons toggling
        for (int i = 0; i < 4; i++) begin
            btn = 3'($urandom_range(0, 7));
            tick();
            zeros("rst_hold");
        end
        btn = 3'b000;
        rst = 1'b1;
        tick();
        tick();
        zeros("rst_rel");

        // Mixed vote sequence
        do_reset();
        press(0, "seq");
        press(1, "seq");
        press(0, "seq");
        press(2, "seq");
        press(1, "seq");
        press(1, "seq");
        press(0, "seq");
        press(2, "seq");
        close_poll("seq_close");

        // Presses after close and reopening attempt
        for (int i = 0; i < 5; i++)
            press(0, "closed");
        vo = 1'b0;
        tick();
        tick();
        push("frozen");
        drain();

        // Long hold counts once
        do_reset();
        btn = 3'b010;
        m[1] = m[1] + 1;
        repeat (20) tick();
        btn = 3'b000;
        tick();
        zeros("hold");
        close_poll("hold_close");

        // Simultaneous press rejected
        do_reset();
        btn = 3'b101;
        tick();
        btn = 3'b000;
        tick();
        tick();
        close_poll("simul");

        // Close wins over a same-cycle vote
        do_reset();
        press(0, "race");
        btn    = 3'b010;
        vo     = 1'b1;
        closed = 1'b1;
        push("race_close");
        tick();
        btn = 3'b000;
        tick();
        drain();

        // Saturation on the narrow instance
        do_reset();
        for (int i = 0; i < 5; i++)
            press(0, "sat");
        close_poll("sat_close");

        // Async reset mid-cycle while closed
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        zeros("async_rst");
        tick();
        rst    = 1'b1;
        m      = '{0, 0, 0};
        closed = 1'b0;
        vo     = 1'b0;
        press(2, "post_rst");
        close_poll("post_rst_close");

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end
endmodule
